// File: rtl/sprite_pkg.sv
// Shared constants, pixel type and line-length helper for the sprite pixel pipeline.
package sprite_pkg;

   localparam int PIX_W_DEF       = 2;
   localparam int WORD_W_DEF      = 32;
   localparam int WORDS_DEF       = 2;
   localparam int PIX_TRANSPARENT = 0;

   typedef logic [PIX_W_DEF-1:0] pixel_t;

   function automatic int npix_f(input int pix_w, input int word_w, input int words);
      return (words * word_w) / pix_w;
   endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// Shadow line buffer: collects WORDS load words, flags full, and presents the
// whole line in parallel with word 0 in the MSBs.
module sprite_line_buf
   import sprite_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORDS  = WORDS_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ld_i,
   input  logic [WORD_W-1:0]       data_i,
   input  logic                    take_i,
   output logic                    ld_ready_o,
   output logic                    full_o,
   output logic [WORDS*WORD_W-1:0] line_o
);

   localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS - 1);

   logic [WORD_W-1:0] shadow_q [WORDS];
   logic [PTR_W-1:0]  wptr_q;
   logic              full_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the line storage is explicitly cleared on reset so a start
         // after reset can never shift out stale pixels.
         for (int w = 0; w < WORDS; w++) shadow_q[w] <= '0;
         wptr_q <= '0;
         full_q <= 1'b0;
      end else if (ld_i && !full_q) begin
         shadow_q[wptr_q] <= data_i;
         if (wptr_q == PTR_LAST) begin
            wptr_q <= '0;
            full_q <= 1'b1;
         end else begin
            wptr_q <= wptr_q + 1'b1;
         end
      end else if (take_i) begin
         full_q <= 1'b0;
      end
   end

   for (genvar w = 0; w < WORDS; w++) begin : g_line
      assign line_o[(WORDS-1-w)*WORD_W +: WORD_W] = shadow_q[w];
   end

   assign full_o     = full_q;
   assign ld_ready_o = !full_q;

endmodule

// File: rtl/sprite_line_shifter.sv
// Double-buffered sprite line serialiser with optional per-line horizontal flip.
// Define SPRITE_SCALE_EN to add the 2-bit scale input (each pixel repeats 2^scale times).
module sprite_line_shifter
   import sprite_pkg::*;
#(
   parameter int PIX_W  = PIX_W_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORDS  = WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld,
   input  logic [WORD_W-1:0] data_in,
   output logic              ld_ready,
   input  logic              start,
   input  logic              flip,
`ifdef SPRITE_SCALE_EN
   input  logic [1:0]        scale,
`endif
   input  logic              en,
   output logic              busy,
   output logic              done,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_valid
);

   localparam int NPIX   = npix_f(PIX_W, WORD_W, WORDS);
   localparam int LINE_W = WORDS * WORD_W;
   localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);

   logic [LINE_W-1:0] line_w;
   logic              full_w;
   logic              start_acc;
   logic              shift;
   logic              last_rep;

   logic [LINE_W-1:0] active_q, active_d;
   logic              flip_q, flip_d;
   logic              busy_q, busy_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  eff_idx;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [PIX_W-1:0]  pix_arr [NPIX];
`ifdef SPRITE_SCALE_EN
   logic [2:0]        rep_q, rep_d;
   logic [1:0]        scale_q, scale_d;
`endif

   assign start_acc = start && full_w;
   assign shift     = en && busy_q && !start_acc;

   sprite_line_buf #(
      .WORD_W (WORD_W),
      .WORDS  (WORDS)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .ld_i       (ld),
      .data_i     (data_in),
      .take_i     (start_acc),
      .ld_ready_o (ld_ready),
      .full_o     (full_w),
      .line_o     (line_w)
   );

   always_comb begin
      for (int k = 0; k < NPIX; k++) pix_arr[k] = active_q[LINE_W-1-k*PIX_W -: PIX_W];
   end

   assign eff_idx = flip_q ? (IDX_LAST - idx_q) : idx_q;

`ifdef SPRITE_SCALE_EN
   assign last_rep = (rep_q == ((3'd1 << scale_q) - 3'd1));
`else
   assign last_rep = 1'b1;
`endif

   // NOTE: every next-state signal gets a default first so no path through
   // this block leaves a value unassigned and infers a latch.
   always_comb begin
      active_d = active_q;
      flip_d   = flip_q;
      busy_d   = busy_q;
      idx_d    = idx_q;
      pix_d    = PIX_W'(PIX_TRANSPARENT);
      valid_d  = 1'b0;
      done_d   = 1'b0;
`ifdef SPRITE_SCALE_EN
      rep_d    = rep_q;
      scale_d  = scale_q;
`endif
      if (start_acc) begin
         active_d = line_w;
         flip_d   = flip;
         busy_d   = 1'b1;
         idx_d    = '0;
`ifdef SPRITE_SCALE_EN
         rep_d    = '0;
         scale_d  = scale;
`endif
      end else if (shift) begin
         pix_d   = pix_arr[eff_idx];
         valid_d = 1'b1;
         if (last_rep) begin
`ifdef SPRITE_SCALE_EN
            rep_d = '0;
`endif
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
`ifdef SPRITE_SCALE_EN
         end else begin
            rep_d = rep_q + 3'd1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= '0;
         flip_q   <= 1'b0;
         busy_q   <= 1'b0;
         idx_q    <= '0;
         pix_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
`ifdef SPRITE_SCALE_EN
         rep_q    <= '0;
         scale_q  <= '0;
`endif
      end else begin
         active_q <= active_d;
         flip_q   <= flip_d;
         busy_q   <= busy_d;
         idx_q    <= idx_d;
         pix_q    <= pix_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
`ifdef SPRITE_SCALE_EN
         rep_q    <= rep_d;
         scale_q  <= scale_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pix_out   = pix_q;
   assign pix_valid = valid_q;

endmodule

// File: tb/tb_sprite_line_shifter.sv
// Scoreboard bench for sprite_line_shifter at default parameters (NPIX = 32).
module tb_sprite_line_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld;
   logic [31:0] data_in;
   logic        ld_ready;
   logic        start;
   logic        flip;
   logic        en;
   logic        busy;
   logic        done;
   logic [1:0]  pix_out;
   logic        pix_valid;
`ifdef SPRITE_SCALE_EN
   logic [1:0]  scale;
`endif

   always #5 clk = ~clk;

   sprite_line_shifter dut (
      .clk       (clk),
      .reset     (reset),
      .ld        (ld),
      .data_in   (data_in),
      .ld_ready  (ld_ready),
      .start     (start),
      .flip      (flip),
`ifdef SPRITE_SCALE_EN
      .scale     (scale),
`endif
      .en        (en),
      .busy      (busy),
      .done      (done),
      .pix_out   (pix_out),
      .pix_valid (pix_valid)
   );

   typedef struct packed {
      logic [1:0] pix;
      logic       done;
   } want_t;

   want_t      sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [1:0] next_exp [32];
   logic [1:0] cur_exp  [32];
   bit         m_busy, m_full, m_flip, mon_en;
   int         m_idx, m_rep, m_reps, m_scale, m_wcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Line A = {0xE4000000, 0x00000009}: pixels 3,2,1,0, zeros, 0,0,2,1
   task automatic set_line_a();
      for (int i = 0; i < 32; i++) next_exp[i] = 2'd0;
      next_exp[0]  = 2'd3; next_exp[1]  = 2'd2; next_exp[2]  = 2'd1; next_exp[3] = 2'd0;
      next_exp[30] = 2'd2; next_exp[31] = 2'd1;
   endtask

   // Line B = {0x1B000000, 0x80000000}: pixels 0,1,2,3, zeros, pixel 16 = 2
   task automatic set_line_b();
      for (int i = 0; i < 32; i++) next_exp[i] = 2'd0;
      next_exp[1] = 2'd1; next_exp[2] = 2'd2; next_exp[3] = 2'd3; next_exp[16] = 2'd2;
   endtask

   task automatic cycle(input bit e, input bit s, input bit f, input bit l, input logic [31:0] d);
      bit    ld_ok;
      int    eff;
      bit    last;
      want_t w;
      en = e; start = s; flip = f; ld = l; data_in = d;
`ifdef SPRITE_SCALE_EN
      scale = 2'(m_scale);
`endif
      ld_ok = l && !m_full;
      if (s && m_full) begin
         cur_exp = next_exp;
         m_busy  = 1'b1;
         m_flip  = f;
         m_idx   = 0;
         m_rep   = 0;
`ifdef SPRITE_SCALE_EN
         m_reps  = 1 << m_scale;
`else
         m_reps  = 1;
`endif
         m_full  = 1'b0;
      end else if (e && m_busy) begin
         eff    = m_flip ? 31 - m_idx : m_idx;
         last   = (m_rep == m_reps - 1);
         w.pix  = cur_exp[eff];
         w.done = last && (m_idx == 31);
         sb_q.push_back(w);
         if (last) begin
            m_rep = 0;
            if (m_idx == 31) m_busy = 1'b0;
            m_idx++;
         end else begin
            m_rep++;
         end
      end
      if (ld_ok) begin
         m_wcnt++;
         if (m_wcnt == 2) begin
            m_wcnt = 0;
            m_full = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_line(input logic [31:0] w0, input logic [31:0] w1);
      cycle(0, 0, 0, 1, w0);
      cycle(0, 0, 0, 1, w1);
      cycle(0, 0, 0, 0, 32'h0);
   endtask

   task automatic clear_model();
      m_busy = 1'b0; m_full = 1'b0; m_flip = 1'b0;
      m_idx = 0; m_rep = 0; m_reps = 1; m_wcnt = 0;
   endtask

   // Monitor: pops one expectation per valid pixel; idle cycles must be transparent.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (pix_valid === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_pix_valid", 32'(pix_valid), 32'd0);
               end else begin
                  want_t w;
                  w = sb_q.pop_front();
                  check("pix_out", 32'(pix_out), 32'(w.pix));
                  check("done", 32'(done), 32'(w.done));
               end
            end else begin
               check("idle_pix_out", 32'(pix_out), 32'd0);
               check("idle_done", 32'(done), 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      mon_en = 1'b0; m_scale = 0;
      clear_model();
      reset = 1'b1; ld = 0; start = 0; flip = 0; en = 0; data_in = '0;
`ifdef SPRITE_SCALE_EN
      scale = 2'd0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // 1. reset state, load, ignored third word
      check("rst_pix_out", 32'(pix_out), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      set_line_a();
      cycle(0, 0, 0, 1, 32'hE400_0000);
      check("ld_ready_after_w0", 32'(ld_ready), 32'd1);
      cycle(0, 0, 0, 1, 32'h0000_0009);
      check("ld_ready_after_w1", 32'(ld_ready), 32'd0);
      cycle(0, 0, 0, 1, 32'hFFFF_FFFF);
      check("ld_ready_after_w2", 32'(ld_ready), 32'd0);

      // 2. unflipped line
      cycle(0, 1, 0, 0, 32'h0);
      check("start_busy", 32'(busy), 32'd1);
      check("start_ld_ready", 32'(ld_ready), 32'd1);
      for (int i = 0; i < 32; i++) begin
         cycle(1, 0, 0, 0, 32'h0);
         if (i == 30) check("busy_before_last", 32'(busy), 32'd1);
      end
      check("last_done", 32'(done), 32'd1);
      check("last_busy", 32'(busy), 32'd0);
      check("last_valid", 32'(pix_valid), 32'd1);
      cycle(0, 0, 0, 0, 32'h0);

      // 3. flipped line
      set_line_a();
      load_line(32'hE400_0000, 32'h0000_0009);
      cycle(0, 1, 1, 0, 32'h0);
      for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 32'h0);
      check("flip_busy_end", 32'(busy), 32'd0);
      cycle(0, 0, 0, 0, 32'h0);

      // 4. en gaps with a reload of line B during shifting
      set_line_a();
      load_line(32'hE400_0000, 32'h0000_0009);
      cycle(0, 1, 0, 0, 32'h0);
      set_line_b();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h0);
      cycle(1, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 1, 32'h1B00_0000);
      check("gap_valid0", 32'(pix_valid), 32'd0);
      cycle(0, 0, 0, 1, 32'h8000_0000);
      check("gap_valid1", 32'(pix_valid), 32'd0);
      check("gap_ld_ready", 32'(ld_ready), 32'd0);
      cycle(1, 0, 0, 0, 32'h0);
      check("gap_resume_valid", 32'(pix_valid), 32'd1);
      for (int i = 0; i < 27; i++) cycle(1, 0, 0, 0, 32'h0);
      check("gap_line_end_busy", 32'(busy), 32'd0);

      // 5. start + en at idx 10 aborts line B, line A restarts at pixel 0
      cycle(0, 1, 0, 0, 32'h0);
      set_line_a();
      for (int i = 0; i < 10; i++) begin
         if (i == 2)      cycle(1, 0, 0, 1, 32'hE400_0000);
         else if (i == 3) cycle(1, 0, 0, 1, 32'h0000_0009);
         else             cycle(1, 0, 0, 0, 32'h0);
      end
      check("abort_shadow_full", 32'(ld_ready), 32'd0);
      cycle(1, 1, 0, 0, 32'h0);
      check("abort_valid", 32'(pix_valid), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 32'h0);
      check("abort_new_line_end", 32'(busy), 32'd0);

      // 6. reset mid-line at idx 5
      set_line_a();
      load_line(32'hE400_0000, 32'h0000_0009);
      cycle(0, 1, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 32'h0);
      reset = 1'b1; en = 1'b1; ld = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(pix_valid), 32'd0);
      check("midrst_ld_ready", 32'(ld_ready), 32'd1);
      reset = 1'b0; en = 1'b0;
      clear_model();

`ifdef SPRITE_SCALE_EN
      set_line_a();
      load_line(32'hE400_0000, 32'h0000_0009);
      m_scale = 2;
      cycle(0, 1, 0, 0, 32'h0);
      for (int i = 0; i < 128; i++) begin
         cycle(1, 0, 0, 0, 32'h0);
         if (i == 126) check("scale_busy_before_last", 32'(busy), 32'd1);
      end
      check("scale_done", 32'(done), 32'd1);
      check("scale_busy_end", 32'(busy), 32'd0);
      m_scale = 0;
`endif

      cycle(0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 32'h0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
